// File: rtl/alif_step_sequencer.sv
// Timestep controller for the dual-leak adaptive LIF neuron: prescaled step timing,
// per-step strobe sequence, slow-leak divider and refractory gating.
// Optional saturating spike counter is enabled by defining ALIF_SPIKE_COUNT_EN.
module alif_step_sequencer #(
  parameter int PER_W = 8,
  parameter int REF_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic       spike_in,
  output logic       in_latch,
  output logic       in_gate,
  output logic       fast_leak_en,
  output logic       slow_leak_en,
  output logic       update_en,
  output logic       step_done,
  output logic       busy,
  output logic [7:0] spike_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LATCH,
    LEAK,
    UPD,
    CHK
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PER_W-1:0] period;
  logic [PER_W-1:0] prescaler;
  logic [PER_W-1:0] pre_load;
  logic [7:0]       slow_div;
  logic [7:0]       slow_cnt;
  logic [REF_W-1:0] refrac;
  logic [REF_W-1:0] ref_cnt;
  logic             en;
  logic             step_req;
  logic             ctrl_we;
  logic             unused_wdata;

  assign ctrl_we      = cfg_we && (cfg_addr == 2'd3);
  // A zero period behaves like a period of one, so WAIT always lasts at least a cycle
  assign pre_load     = (period == '0) ? '0 : period - PER_W'(1);
  assign unused_wdata = ^cfg_wdata;

  assign busy    = (state != IDLE);
  assign in_gate = (ref_cnt == '0);

  // STEP is only captured while idle, so a STEP write landing mid-step never queues a run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period   <= '0;
      slow_div <= '0;
      refrac   <= '0;
      en       <= 1'b0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: period   <= cfg_wdata[PER_W-1:0];
          2'd1: slow_div <= cfg_wdata;
          2'd2: refrac   <= cfg_wdata[REF_W-1:0];
          default: begin
            en       <= cfg_wdata[0];
            step_req <= cfg_wdata[1] && (state == IDLE);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    in_latch     = 1'b0;
    fast_leak_en = 1'b0;
    slow_leak_en = 1'b0;
    update_en    = 1'b0;
    step_done    = 1'b0;
    case (state)
      IDLE: begin
        if (en || step_req) state_next = WAIT;
      end
      WAIT: begin
        if (prescaler == '0) state_next = LATCH;
      end
      LATCH: begin
        in_latch   = 1'b1;
        state_next = LEAK;
      end
      LEAK: begin
        fast_leak_en = 1'b1;
        slow_leak_en = (slow_cnt == slow_div);
        state_next   = UPD;
      end
      UPD: begin
        update_en  = 1'b1;
        state_next = CHK;
      end
      CHK: begin
        step_done  = 1'b1;
        state_next = en ? WAIT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler is reloaded on every WAIT entry, which is where a new PERIOD takes effect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      slow_cnt  <= '0;
      ref_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en || step_req) prescaler <= pre_load;
        end
        WAIT: begin
          if (prescaler != '0) prescaler <= prescaler - PER_W'(1);
        end
        LEAK: begin
          if (slow_cnt == slow_div) slow_cnt <= '0;
          else                      slow_cnt <= slow_cnt + 8'd1;
        end
        CHK: begin
          if (spike_in)              ref_cnt <= refrac;
          else if (ref_cnt != '0)    ref_cnt <= ref_cnt - REF_W'(1);
          if (en) prescaler <= pre_load;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ALIF_SPIKE_COUNT_EN
  logic [7:0] spike_cnt_q;

  // Clear via CTRL bit7 takes priority over a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_cnt_q <= '0;
    end else if (ctrl_we && cfg_wdata[7]) begin
      spike_cnt_q <= '0;
    end else if ((state == CHK) && spike_in && (spike_cnt_q != 8'hFF)) begin
      spike_cnt_q <= spike_cnt_q + 8'd1;
    end
  end

  assign spike_cnt = spike_cnt_q;
`else
  assign spike_cnt = '0;
`endif

endmodule

// File: tb/tb_alif_step_sequencer.sv
// Directed self-checking bench for alif_step_sequencer: reset, step timing,
// slow-leak divider, refractory gating, single-step/disable and async reset.
module tb_alif_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = 2'd0;
  logic [7:0] cfg_wdata = 8'd0;
  logic       spike_in = 1'b0;
  logic       in_latch;
  logic       in_gate;
  logic       fast_leak_en;
  logic       slow_leak_en;
  logic       update_en;
  logic       step_done;
  logic       busy;
  logic [7:0] spike_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  alif_step_sequencer #(.PER_W(8), .REF_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .spike_in(spike_in),
    .in_latch(in_latch),
    .in_gate(in_gate),
    .fast_leak_en(fast_leak_en),
    .slow_leak_en(slow_leak_en),
    .update_en(update_en),
    .step_done(step_done),
    .busy(busy),
    .spike_cnt(spike_cnt)
  );

  always #5 clk = ~clk;

  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    spike_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tests_run++;
      if ({in_latch, fast_leak_en, slow_leak_en, update_en, step_done, busy, in_gate} !== 7'b0000001
          || spike_cnt !== 8'd0) begin
        tests_failed++;
        $display("[TB] FAIL reset_idle cycle %0d: got strobes/busy/gate=%b cnt=%0d, want 0000001 cnt=0", i,
                 {in_latch, fast_leak_en, slow_leak_en, update_en, step_done, busy, in_gate}, spike_cnt);
      end
    end
  endtask

  task automatic test_free_run();
    logic h1, h2, h3;
    int last, nlat;
    do_reset();
    write_reg(2'd0, 8'd6);
    write_reg(2'd1, 8'd0);
    write_reg(2'd3, 8'h01);
    h1 = 0; h2 = 0; h3 = 0; last = -1; nlat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      tests_run++;
      if (fast_leak_en !== h1 || update_en !== h2 || step_done !== h3 || slow_leak_en !== fast_leak_en) begin
        tests_failed++;
        $display("[TB] FAIL free_run_seq cycle %0d: got fast/slow/upd/done=%b%b%b%b, want %b%b%b%b", i,
                 fast_leak_en, slow_leak_en, update_en, step_done, h1, h1, h2, h3);
      end
      if (in_latch) begin
        if (last >= 0) begin
          tests_run++;
          if (i - last != 10) begin
            tests_failed++;
            $display("[TB] FAIL free_run_period: got %0d cycles between latches, want 10", i - last);
          end
        end
        last = i;
        nlat++;
      end
      h3 = h2; h2 = h1; h1 = in_latch;
    end
    tests_run++;
    if (nlat < 5) begin
      tests_failed++;
      $display("[TB] FAIL free_run_count: got %0d latches in 60 cycles, want >= 5", nlat);
    end
    write_reg(2'd3, 8'h00);
  endtask

  task automatic test_slow_div();
    int nfast;
    logic exp_slow;
    do_reset();
    write_reg(2'd0, 8'd1);
    write_reg(2'd1, 8'd2);
    write_reg(2'd3, 8'h01);
    nfast = 0;
    for (int i = 0; i < 100 && nfast < 9; i++) begin
      @(negedge clk);
      if (fast_leak_en) begin
        nfast++;
        exp_slow = (nfast % 3 == 0);
        tests_run++;
        if (slow_leak_en !== exp_slow) begin
          tests_failed++;
          $display("[TB] FAIL slow_div step %0d: got slow_leak_en=%b, want %b", nfast, slow_leak_en, exp_slow);
        end
      end
    end
    tests_run++;
    if (nfast != 9) begin
      tests_failed++;
      $display("[TB] FAIL slow_div_count: got %0d fast leaks, want 9", nfast);
    end
    write_reg(2'd3, 8'h00);
  endtask

  // Spike in CHK of step 2 and optionally step s2; gate low while done_cnt in [2, last_low]
  task automatic test_refractory(input int s2, input int last_low);
    int done_cnt;
    logic exp_gate;
    do_reset();
    write_reg(2'd0, 8'd2);
    write_reg(2'd2, 8'd3);
    write_reg(2'd3, 8'h01);
    done_cnt = 0;
    for (int i = 0; i < 200 && done_cnt < 9; i++) begin
      @(negedge clk);
      spike_in = 1'b0;
      exp_gate = !(done_cnt >= 2 && done_cnt <= last_low);
      tests_run++;
      if (in_gate !== exp_gate) begin
        tests_failed++;
        $display("[TB] FAIL refractory s2=%0d after %0d steps: got in_gate=%b, want %b", s2, done_cnt, in_gate, exp_gate);
      end
      if (step_done) begin
        done_cnt++;
        spike_in = (done_cnt == 2) || (done_cnt == s2);
      end
    end
    tests_run++;
    if (done_cnt != 9) begin
      tests_failed++;
      $display("[TB] FAIL refractory_steps: got %0d steps, want 9", done_cnt);
    end
    write_reg(2'd3, 8'h00);
  endtask

  task automatic test_single_step();
    int nbusy, ndone, nlat;
    do_reset();
    write_reg(2'd0, 8'd3);
    write_reg(2'd3, 8'h02);
    nbusy = 0; ndone = 0; nlat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (step_done) ndone++;
      if (in_latch) nlat++;
    end
    tests_run++;
    if (nbusy != 7 || ndone != 1 || nlat != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_step: got busy_cycles=%0d done=%0d latch=%0d busy=%b, want 7 1 1 0",
               nbusy, ndone, nlat, busy);
    end
  endtask

  task automatic test_en_clear();
    int ndone, nlat;
    logic prev_done;
    do_reset();
    write_reg(2'd0, 8'd6);
    write_reg(2'd3, 8'h01);
    write_reg(2'd3, 8'h00);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL en_clear_busy: got busy=%b after clearing EN in WAIT, want 1", busy);
    end
    ndone = 0; nlat = 0; prev_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prev_done) begin
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL en_clear_idle: got busy=%b after step_done, want 0", busy);
        end
      end
      if (step_done) ndone++;
      if (in_latch) nlat++;
      prev_done = step_done;
    end
    tests_run++;
    if (ndone != 1 || nlat != 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL en_clear: got done=%0d latch=%0d busy=%b, want 1 1 0", ndone, nlat, busy);
    end
  endtask

  task automatic test_async_reset();
    int ndone;
    int nwait;
    logic [7:0] exp_cnt;
`ifdef ALIF_SPIKE_COUNT_EN
    exp_cnt = 8'd255;
`else
    exp_cnt = 8'd0;
`endif
    do_reset();
    write_reg(2'd0, 8'd1);
    spike_in = 1'b1;
    write_reg(2'd3, 8'h01);
    ndone = 0;
    for (int i = 0; i < 2000 && ndone < 300; i++) begin
      @(negedge clk);
      if (step_done) ndone++;
    end
    @(negedge clk);
    spike_in = 1'b0;
    tests_run++;
    if (ndone != 300 || spike_cnt !== exp_cnt) begin
      tests_failed++;
      $display("[TB] FAIL spike_saturate: got steps=%0d spike_cnt=%0d, want 300 %0d", ndone, spike_cnt, exp_cnt);
    end
    nwait = 0;
    while (!update_en && nwait < 20) begin
      @(negedge clk);
      nwait++;
    end
    tests_run++;
    if (update_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_reach_upd: got update_en=%b, want 1", update_en);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (update_en !== 1'b0 || busy !== 1'b0 || in_gate !== 1'b1 || spike_cnt !== 8'd0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got upd=%b busy=%b gate=%b cnt=%0d, want 0 0 1 0",
               update_en, busy, in_gate, spike_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

`ifdef ALIF_SPIKE_COUNT_EN
  task automatic test_spike_clear();
    int ndone;
    do_reset();
    write_reg(2'd0, 8'd1);
    spike_in = 1'b1;
    write_reg(2'd3, 8'h01);
    ndone = 0;
    for (int i = 0; i < 50 && ndone < 2; i++) begin
      @(negedge clk);
      if (step_done) ndone++;
    end
    @(negedge clk);
    spike_in = 1'b0;
    tests_run++;
    if (spike_cnt !== 8'd2) begin
      tests_failed++;
      $display("[TB] FAIL spike_count_two: got %0d, want 2", spike_cnt);
    end
    write_reg(2'd3, 8'h81);
    tests_run++;
    if (spike_cnt !== 8'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL spike_clear: got cnt=%0d busy=%b, want 0 1", spike_cnt, busy);
    end
    write_reg(2'd3, 8'h00);
  endtask
`endif

  initial begin
    test_reset();
    test_free_run();
    test_slow_div();
    test_refractory(0, 4);
    test_refractory(4, 6);
    test_single_step();
    test_en_clear();
    test_async_reset();
`ifdef ALIF_SPIKE_COUNT_EN
    test_spike_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alif_step_sequencer.md
Name: alif_step_sequencer

Overview:
- Timestep controller for the dual-leak adaptive LIF neuron datapath.
- Divides clk into programmable timesteps and runs a fixed per-step strobe sequence: latch input, leak, update, spike check.
- Applies the slow leak every Nth step and gates input during a programmable refractory window after each spike.
- Configured through a small byte-wide register port driven from the top-level IO.

Parameters:
- PER_W, 8, width of the prescaler period register and counter.
- REF_W, 4, width of the refractory step count.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- cfg_we  input  1  register write strobe, one cycle per write.
- cfg_addr  input  2  register address.
- cfg_wdata  input  8  register write data.
- spike_in  input  1  spike flag from the neuron datapath, valid in CHK.
- in_latch  output  1  one-cycle strobe: neuron samples its input current.
- in_gate  output  1  1 = input path enabled; 0 = refractory.
- fast_leak_en  output  1  one-cycle strobe: apply fast leak.
- slow_leak_en  output  1  one-cycle strobe: apply slow/adaptive leak.
- update_en  output  1  one-cycle strobe: integrate and threshold compare.
- step_done  output  1  one-cycle strobe at the end of each step.
- busy  output  1  1 whenever state != IDLE.
- spike_cnt  output  8  saturating spike count (optional feature).

Behaviour:
- Registers, all reset to 0:
  - addr0: PERIOD[PER_W-1:0].
  - addr1: SLOW_DIV[7:0].
  - addr2: REFRAC[REF_W-1:0]; upper bits ignored.
  - addr3: CTRL. bit0 = EN (persistent); bit1 = STEP (self-clearing; reads as 0 the cycle after the write).
- Writes are sampled on the clk edge where cfg_we=1. A new PERIOD takes effect at the next WAIT entry.
- Reset value of every output is 0, except in_gate=1. FSM resets to IDLE and all internal counters to 0.
- FSM states: IDLE, WAIT, LATCH, LEAK, UPD, CHK.
  - IDLE: stay until EN=1 or STEP=1. On exit, load the prescaler with max(PERIOD,1)-1 and go to WAIT. A STEP write in IDLE runs exactly one step. STEP writes outside IDLE are ignored.
  - WAIT: decrement the prescaler each cycle; at 0 go to LATCH.
  - LATCH: in_latch=1 for one cycle. Go to LEAK.
  - LEAK: fast_leak_en=1. If slow_cnt==SLOW_DIV, then slow_leak_en=1 and slow_cnt clears; otherwise slow_cnt increments. SLOW_DIV=0 means slow leak every step. Go to UPD.
  - UPD: update_en=1. Go to CHK.
  - CHK: sample spike_in.
    - If spike_in=1: load ref_cnt with REFRAC and increment spike_cnt.
    - Else if ref_cnt!=0: decrement ref_cnt.
    - step_done=1.
    - If EN=1, reload the prescaler and go to WAIT; else go to IDLE.
- Step length is exactly max(PERIOD,1)+4 cycles. Back-to-back steps have no idle gap.
- in_gate = (ref_cnt==0). It is combinational from the register, so gating begins the cycle after the CHK that saw the spike. REFRAC=0 never gates.
- A spike during refractory reloads ref_cnt; it does not extend ref_cnt cumulatively.
- Clearing EN mid-step does not abort: the current step completes through CHK, then the FSM goes to IDLE. Setting EN while in IDLE starts a step on the next cycle.
- Strobes are mutually exclusive except fast_leak_en with slow_leak_en. At most one strobe per cycle otherwise.
- Asserting rst mid-step immediately forces IDLE, zeroes all strobes and counters, and sets in_gate=1.
- PER_W counter wrap is impossible: the prescaler only counts down from a loaded value.

Optional Feature:
- Macro: ALIF_SPIKE_COUNT_EN.
- Defined: spike_cnt increments on each CHK with spike_in=1 and saturates at 255. A write of any value to addr3 with bit7=1 clears it; the other CTRL bits in that write still apply.
- Not defined: spike_cnt is tied to 0, no counter flops exist, and CTRL bit7 is ignored.

Test Plan:
- Reset, then idle: rst pulse, no writes -> all strobes 0, in_gate=1, busy=0 for 50 cycles.
- Free-run timing: PERIOD=6, SLOW_DIV=0, EN=1 -> in_latch every 10 cycles; LEAK/UPD/CHK strobes follow in_latch at +1/+2/+3 cycles; slow_leak_en on every step.
- Slow-leak divider: PERIOD=1, SLOW_DIV=2, EN=1, run 9 steps -> slow_leak_en on steps 3, 6, 9 only; fast_leak_en on all 9.
- Refractory: REFRAC=3, spike_in=1 in CHK of step 2 only -> in_gate=0 from the cycle after that CHK through the CHK of step 5, and 1 thereafter. A second spike at step 4 -> gate extends through step 7.
- Single-step and disable: EN=0, write CTRL=0x02 -> exactly one step (PERIOD+4 cycles), then busy=0. Separately, with EN=1, clear EN during WAIT -> the step finishes with step_done, then IDLE.
- Async reset mid-step (plus ALIF_SPIKE_COUNT_EN): 300 spikes -> spike_cnt=255. Assert rst during UPD -> spike_cnt=0, state IDLE, and update_en drops without waiting for a clk edge.
